// File: rtl/uart_rx_if.sv
// ---------------------------------------------------------------------------
// uart_rx_if
// Purpose : bundles the parallel-side outputs of the UART receiver so the
//           receiver and its consumer (interface/ALU control) share one port.
// Signals :
//   o_rx_done   - one-cycle pulse, o_data updated with a valid frame
//   o_frame_err - one-cycle pulse, stop bit sampled low, frame dropped
//   o_data      - last correctly received data word
// Modports:
//   master - the receiver (drives all signals)
//   slave  - the downstream consumer (reads all signals)
// ---------------------------------------------------------------------------
interface uart_rx_if #(
  parameter int unsigned NBITS_DATA = 8
);

  logic                  o_rx_done;
  logic                  o_frame_err;
  logic [NBITS_DATA-1:0] o_data;

  modport master (
    output o_rx_done,
    output o_frame_err,
    output o_data
  );

  modport slave (
    input o_rx_done,
    input o_frame_err,
    input o_data
  );

endinterface

// File: rtl/uart_rx.sv
// ---------------------------------------------------------------------------
// uart_rx
// Purpose : UART receiver, 1 start bit, NBITS_DATA data bits LSB first,
//           1 stop bit, no parity. Oversamples the line with the shared
//           baud-rate-generator tick (STOPBITS_TCK ticks per bit) and
//           samples each bit in its middle.
// Ports   :
//   i_clk       - system clock, rising edge
//   i_reset     - synchronous active-high reset
//   i_rx        - asynchronous serial line, idle high
//   i_tick_brg  - one-cycle oversampling tick
//   bus         - uart_rx_if.master: o_rx_done, o_frame_err, o_data
// ---------------------------------------------------------------------------
module uart_rx #(
  parameter int unsigned NBITS_DATA   = 8,
  parameter int unsigned STOPBITS_TCK = 16
) (
  input  logic      i_clk,
  input  logic      i_reset,
  input  logic      i_rx,
  input  logic      i_tick_brg,
  uart_rx_if.master bus
);

  localparam int unsigned NB_CNT  = (STOPBITS_TCK > 2) ? $clog2(STOPBITS_TCK) : 1;
  localparam int unsigned NB_DCNT = (NBITS_DATA > 1)   ? $clog2(NBITS_DATA)   : 1;

  localparam logic [NB_CNT-1:0]  MID_START = NB_CNT'(STOPBITS_TCK / 2 - 1);
  localparam logic [NB_CNT-1:0]  MID_BIT   = NB_CNT'(STOPBITS_TCK - 1);
  localparam logic [NB_DCNT-1:0] LAST_BIT  = NB_DCNT'(NBITS_DATA - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } state_t;

  // Two-flop synchroniser; both stages reset to the idle (high) line level.
  logic r_rx_meta;
  logic r_rx_s;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_rx_meta <= 1'b1;
      r_rx_s    <= 1'b1;
    end else begin
      r_rx_meta <= i_rx;
      r_rx_s    <= r_rx_meta;
    end
  end

  state_t                r_state;
  logic [NB_CNT-1:0]     r_cnt;
  logic [NB_DCNT-1:0]    r_dcnt;
  logic [NBITS_DATA-1:0] r_shift;
  logic [NBITS_DATA-1:0] r_data;
  logic                  r_rx_done;
  logic                  r_frame_err;

  // Shift register next value: new bit enters at the MSB so the first
  // received bit ends up in bit 0 after NBITS_DATA shifts.
  logic [NBITS_DATA-1:0] w_shift_next;

  always_comb begin
    w_shift_next                 = r_shift >> 1;
    w_shift_next[NBITS_DATA-1]   = r_rx_s;
  end

  // Receive FSM with registered strobes and data.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state     <= ST_IDLE;
      r_cnt       <= '0;
      r_dcnt      <= '0;
      r_shift     <= '0;
      r_data      <= '0;
      r_rx_done   <= 1'b0;
      r_frame_err <= 1'b0;
    end else begin
      r_rx_done   <= 1'b0;
      r_frame_err <= 1'b0;

      case (r_state)
        ST_IDLE: begin
          // Falling edge detection does not wait for a tick.
          if (!r_rx_s) begin
            r_state <= ST_START;
            r_cnt   <= '0;
          end
        end

        ST_START: begin
          if (i_tick_brg) begin
            if (r_cnt == MID_START) begin
              // Line back high at mid start bit: treat as a glitch.
              if (!r_rx_s) begin
                r_state <= ST_DATA;
                r_cnt   <= '0;
                r_dcnt  <= '0;
              end else begin
                r_state <= ST_IDLE;
              end
            end else begin
              r_cnt <= r_cnt + NB_CNT'(1);
            end
          end
        end

        ST_DATA: begin
          if (i_tick_brg) begin
            if (r_cnt == MID_BIT) begin
              r_shift <= w_shift_next;
              r_cnt   <= '0;
              if (r_dcnt == LAST_BIT) begin
                r_state <= ST_STOP;
              end else begin
                r_dcnt <= r_dcnt + NB_DCNT'(1);
              end
            end else begin
              r_cnt <= r_cnt + NB_CNT'(1);
            end
          end
        end

        ST_STOP: begin
          if (i_tick_brg) begin
            if (r_cnt == MID_BIT) begin
              // Returning to IDLE at mid stop bit allows back-to-back frames.
              r_state <= ST_IDLE;
              if (r_rx_s) begin
                r_data    <= r_shift;
                r_rx_done <= 1'b1;
              end else begin
                r_frame_err <= 1'b1;
              end
            end else begin
              r_cnt <= r_cnt + NB_CNT'(1);
            end
          end
        end

        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.o_rx_done   = r_rx_done;
  assign bus.o_frame_err = r_frame_err;
  assign bus.o_data      = r_data;

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- UART receiver; counterpart to the team's UART transmitter. Shares its baud-rate generator tick (16x oversampling) and frame format: 1 start bit, NBITS_DATA data bits LSB first, 1 stop bit, no parity.
- Produces a parallel byte and a one-cycle done strobe for the downstream interface/ALU control logic.
- Also flags framing errors.

Parameters:
- NBITS_DATA, 8, data bits per frame.
- STOPBITS_TCK, 16, ticks per bit period. Applies to the start-to-data, data-bit and stop-bit intervals. Must be even and at least 4.

Ports:
- i_clk  input  1  system clock, all logic on rising edge.
- i_reset  input  1  synchronous, active-high reset.
- i_rx  input  1  serial line, asynchronous, idle high.
- i_tick_brg  input  1  one-cycle oversampling tick from the baud-rate generator.
- o_rx_done  output  1  one-cycle pulse: valid frame received, o_data updated this cycle.
- o_frame_err  output  1  one-cycle pulse: stop bit sampled low, frame discarded.
- o_data  output  NBITS_DATA  last correctly received byte. Held until the next valid frame.

Behaviour:
- Input synchroniser:
  - i_rx passes through a 2-flop synchroniser; both flops reset to 1.
  - The FSM sees only the synchronised value rx_s, 2 cycles after i_rx.
- Reset:
  - state=IDLE, sampling counter=0, data counter=0, shift register=0.
  - o_data=0, o_rx_done=0, o_frame_err=0.
  - Reset mid-frame aborts the frame; no strobe is emitted.
- Sampling counter: width $clog2(STOPBITS_TCK). Counts i_tick_brg only; cycles without a tick change nothing.
- IDLE:
  - When rx_s==0, go to START with counter=0. A tick is not required.
- START:
  - On each tick, counter+1.
  - On the tick where counter==STOPBITS_TCK/2-1 (mid start bit):
    - rx_s==0: go to DATA, counters=0.
    - rx_s==1: glitch; go back to IDLE. No strobes.
- DATA:
  - On each tick, counter+1.
  - On the tick where counter==STOPBITS_TCK-1 (mid data bit):
    - shift = {rx_s, shift[NBITS_DATA-1:1]}, i.e. LSB first.
    - counter=0.
    - If data counter==NBITS_DATA-1, go to STOP; otherwise data counter+1.
- STOP:
  - On each tick, counter+1.
  - On the tick where counter==STOPBITS_TCK-1 (mid stop bit), go to IDLE and:
    - rx_s==1: o_data<=shift and o_rx_done=1 for exactly that one cycle.
    - rx_s==0: o_frame_err=1 for that one cycle; o_data unchanged.
- After STOP the FSM is back in IDLE at mid stop bit. A following start bit is accepted with no extra idle time, so back-to-back frames are supported.
- If the line is still low after a framing error, IDLE immediately re-enters START. This is the defined break behaviour; each such frame is checked independently.
- o_rx_done and o_frame_err are never high together, and are never high two consecutive cycles.
- Outputs are registered.
- Latency: done pulse follows the clock edge of the mid-stop-bit tick, plus 2 cycles of synchroniser delay relative to i_rx.

Test Plan:
- Setup for all cases: tick every 4 clocks, STOPBITS_TCK=16, bit period 64 clocks.
- Valid frame: send 0xA5 (line sequence 0,1,0,1,0,0,1,0,1,1) -> exactly one o_rx_done pulse about 9.5 bit periods after the falling edge; o_data=0xA5; o_frame_err never asserted.
- Extremes back-to-back: 0x00, then 0xFF, then 0x3C with zero idle between frames -> three done pulses, o_data=0x00, 0xFF, 0x3C in order.
- Glitch rejection: drive i_rx low for 3 ticks (12 clocks), then high -> FSM returns to IDLE; no done or error pulse; o_data unchanged.
- Framing error: send 0x5A with the stop bit driven low -> one o_frame_err pulse, no o_rx_done, o_data keeps its previous value. Then a valid 0x81 frame after 2 bit periods of idle -> o_rx_done, o_data=0x81.
- Reset mid-frame: assert i_reset for 1 cycle during data bit 4 of 0xC3 -> no strobes; o_data=0. A subsequent clean 0xC3 frame -> o_rx_done, o_data=0xC3.
- Tick gating: hold i_tick_brg=0 for 200 clocks in the middle of DATA -> state and counters frozen. Resuming ticks with the waveform stretched to match -> correct byte received.
